// File: rtl/crtc_ctrl.sv
// crtc_ctrl: host register bus and frame-synchronous timing loader for the CRTC.
// Optional frame interrupt enabled by defining CRTC_CTRL_IRQ_EN.
module crtc_ctrl #(
    parameter int WIDTH = 10
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [3:0]       adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             ack_o,
    input  logic             vsync_i,
    output logic [WIDTH-1:0] hsynct_o,
    output logic [WIDTH-1:0] hbporch_o,
    output logic [WIDTH-1:0] hactive_o,
    output logic [WIDTH-1:0] hfporch_o,
    output logic [WIDTH-1:0] vsynct_o,
    output logic [WIDTH-1:0] vbporch_o,
    output logic [WIDTH-1:0] vactive_o,
    output logic [WIDTH-1:0] vfporch_o,
    output logic             enable_o,
    output logic             irq_o
);
    typedef enum logic [1:0] {IDLE, RUN, PEND, LOAD} state_t;

    localparam logic [WIDTH-1:0] RST_VAL [8] = '{WIDTH'(11), WIDTH'(17), WIDTH'(97), WIDTH'(99),
                                                 WIDTH'(1), WIDTH'(34), WIDTH'(514), WIDTH'(524)};

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh [8];
    logic [WIDTH-1:0] act [8];
    logic [WIDTH-1:0] rdata;
    logic [4:0]       ctrl_bits;
    logic             req, wr, wr_ctrl, commit, valid, vs_edge, vs_q;
    logic             en, err, irq_bit, pend_bit, copy_req, copy_req_nx, copy_now, load2;

    assign req      = cyc_i & stb_i & ~ack_o;
    assign wr       = req & we_i;
    assign wr_ctrl  = wr & (adr_i == 4'd8);
    assign commit   = wr_ctrl & dat_i[1];
    assign vs_edge  = vsync_i & ~vs_q;
    assign pend_bit = (state == PEND) || (state == LOAD);
    assign valid    = (sh[0] < sh[1]) && (sh[1] < sh[2]) && (sh[2] < sh[3]) &&
                      (sh[4] < sh[5]) && (sh[5] < sh[6]) && (sh[6] < sh[7]);
    assign ctrl_bits = {irq_bit, err, pend_bit, 1'b0, en};
    assign rdata     = adr_i[3] ? ((adr_i[2:0] == 3'd0) ? WIDTH'(ctrl_bits) : '0) : sh[adr_i[2:0]];

    assign hsynct_o  = act[0];
    assign hbporch_o = act[1];
    assign hactive_o = act[2];
    assign hfporch_o = act[3];
    assign vsynct_o  = act[4];
    assign vbporch_o = act[5];
    assign vactive_o = act[6];
    assign vfporch_o = act[7];

    always_comb begin
        state_nx    = state;
        copy_now    = copy_req;
        copy_req_nx = 1'b0;
        case (state)
            IDLE: begin
                copy_req_nx = commit & valid;
                if (wr_ctrl && dat_i[0]) state_nx = RUN;
            end
            RUN: begin
                if (wr_ctrl && !dat_i[0]) begin
                    state_nx    = IDLE;
                    copy_req_nx = commit & valid;
                end else if (commit && valid) state_nx = PEND;
            end
            PEND: begin
                // Disabling mid-wait applies the pending timing at once instead of dropping it.
                if (wr_ctrl && !dat_i[0]) begin
                    copy_now = 1'b1;
                    state_nx = IDLE;
                end else if (commit && !valid) state_nx = RUN;
                else if (vs_edge) begin
                    copy_now = 1'b1;
                    state_nx = LOAD;
                end
            end
            default: if (load2) state_nx = en ? RUN : IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            ack_o    <= 1'b0;
            dat_o    <= '0;
            vs_q     <= 1'b0;
            en       <= 1'b0;
            err      <= 1'b0;
            copy_req <= 1'b0;
            load2    <= 1'b0;
            enable_o <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                sh[i]  <= RST_VAL[i];
                act[i] <= RST_VAL[i];
            end
        end else begin
            state    <= state_nx;
            ack_o    <= req;
            dat_o    <= (req && !we_i) ? rdata : '0;
            vs_q     <= vsync_i;
            copy_req <= copy_req_nx;
            load2    <= (state == LOAD) && !load2;
            enable_o <= (state_nx == RUN) || (state_nx == PEND);
            if (wr_ctrl) en <= dat_i[0];
            if (commit) err <= ~valid;
            if (wr && !adr_i[3]) sh[adr_i[2:0]] <= dat_i;
            if (copy_now)
                for (int i = 0; i < 8; i++) act[i] <= sh[i];
        end
    end

`ifdef CRTC_CTRL_IRQ_EN
    logic irq;
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) irq <= 1'b0;
        else if (vs_edge) irq <= 1'b1;
        else if (wr_ctrl && dat_i[4]) irq <= 1'b0;
    end
    assign irq_bit = irq;
`else
    assign irq_bit = 1'b0;
`endif
    assign irq_o = irq_bit;
endmodule

// File: tb/tb_crtc_ctrl.sv
// tb_crtc_ctrl: directed self-checking bench for crtc_ctrl (default build, IRQ feature off).
module tb_crtc_ctrl;
    logic       clock_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, vsync_i = 1'b0;
    logic [3:0] adr_i = '0;
    logic [9:0] dat_i = '0;
    logic [9:0] dat_o, hsynct_o, hbporch_o, hactive_o, hfporch_o;
    logic [9:0] vsynct_o, vbporch_o, vactive_o, vfporch_o;
    logic       ack_o, enable_o, irq_o;
    logic [9:0] rd_val;
    int         checks = 0;
    int         failures = 0;

    crtc_ctrl #(.WIDTH(10)) dut (
        .clock_i(clock_i), .reset_ni(reset_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .vsync_i(vsync_i),
        .hsynct_o(hsynct_o), .hbporch_o(hbporch_o), .hactive_o(hactive_o), .hfporch_o(hfporch_o),
        .vsynct_o(vsynct_o), .vbporch_o(vbporch_o), .vactive_o(vactive_o), .vfporch_o(vfporch_o),
        .enable_o(enable_o), .irq_o(irq_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [9:0] d);
        @(negedge clock_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
        @(posedge clock_i); #1;
        chk("wr_ack", ack_o, 1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clock_i); #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [9:0] d);
        @(negedge clock_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = a;
        @(posedge clock_i); #1;
        chk("rd_ack", ack_o, 1);
        d = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clock_i); #1;
    endtask

    task automatic vs_pulse();
        @(negedge clock_i); vsync_i = 1'b1;
        @(posedge clock_i); #1;
    endtask

    initial begin
        // 1: reset values
        #12;
        chk("rst_hsynct", hsynct_o, 11);
        chk("rst_hbporch", hbporch_o, 17);
        chk("rst_hactive", hactive_o, 97);
        chk("rst_hfporch", hfporch_o, 99);
        chk("rst_vsynct", vsynct_o, 1);
        chk("rst_vbporch", vbporch_o, 34);
        chk("rst_vactive", vactive_o, 514);
        chk("rst_vfporch", vfporch_o, 524);
        chk("rst_enable", enable_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_irq", irq_o, 0);
        @(negedge clock_i); reset_ni = 1'b1;
        rd(4'd8, rd_val); chk("rst_ctrl", rd_val, 0);
        rd(4'd12, rd_val); chk("unmapped_rd", rd_val, 0);

        // 2: commit while idle loads immediately
        wr(4'd2, 10'd81);
        wr(4'd3, 10'd83);
        chk("idle_pre_commit", hactive_o, 97);
        wr(4'd8, 10'h002);
        chk("idle_hactive", hactive_o, 81);
        chk("idle_hfporch", hfporch_o, 83);
        rd(4'd8, rd_val); chk("idle_ctrl", rd_val, 0);
        rd(4'd2, rd_val); chk("shadow_rd", rd_val, 81);
        wr(4'd12, 10'd55);
        rd(4'd12, rd_val); chk("unmapped_wr", rd_val, 0);

        // 3: commit while running waits for vsync and blanks for two cycles
        wr(4'd8, 10'h001);
        chk("run_enable", enable_o, 1);
        wr(4'd6, 10'd400);
        wr(4'd7, 10'd410);
        wr(4'd8, 10'h003);
        rd(4'd8, rd_val); chk("pend_ctrl", rd_val, 10'h005);
        repeat (3) @(posedge clock_i); #1;
        chk("pend_vactive_hold", vactive_o, 514);
        chk("pend_enable", enable_o, 1);
        vs_pulse();
        chk("load1_enable", enable_o, 0);
        chk("load1_vactive", vactive_o, 400);
        chk("load1_vfporch", vfporch_o, 410);
        @(posedge clock_i); #1;
        chk("load2_enable", enable_o, 0);
        @(posedge clock_i); #1;
        chk("post_load_enable", enable_o, 1);
        chk("no_irq", irq_o, 0);
        rd(4'd8, rd_val); chk("post_load_ctrl", rd_val, 10'h001);
        @(negedge clock_i); vsync_i = 1'b0;

        // 4: invalid commit flags ERR and changes nothing
        wr(4'd1, 10'd20);
        wr(4'd2, 10'd15);
        wr(4'd8, 10'h003);
        rd(4'd8, rd_val); chk("err_ctrl", rd_val, 10'h009);
        chk("err_hbporch", hbporch_o, 17);
        chk("err_hactive", hactive_o, 81);
        wr(4'd2, 10'd97);
        wr(4'd3, 10'd99);
        wr(4'd8, 10'h003);
        rd(4'd8, rd_val); chk("fix_ctrl", rd_val, 10'h005);
        // an invalid recommit cancels the pending load
        wr(4'd2, 10'd5);
        wr(4'd8, 10'h003);
        rd(4'd8, rd_val); chk("cancel_ctrl", rd_val, 10'h009);
        vs_pulse();
        chk("cancel_enable", enable_o, 1);
        chk("cancel_hactive", hactive_o, 81);
        @(negedge clock_i); vsync_i = 1'b0;
        wr(4'd2, 10'd97);
        wr(4'd8, 10'h003);
        vs_pulse();
        chk("reload_hbporch", hbporch_o, 20);
        chk("reload_hactive", hactive_o, 97);
        chk("reload_hfporch", hfporch_o, 99);
        repeat (2) @(posedge clock_i); #1;
        @(negedge clock_i); vsync_i = 1'b0;
        rd(4'd8, rd_val); chk("reload_ctrl", rd_val, 10'h001);

        // commit coinciding with a vsync edge waits for the following edge
        wr(4'd0, 10'd12);
        @(negedge clock_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 4'd8; dat_i = 10'h003; vsync_i = 1'b1;
        @(posedge clock_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        repeat (3) @(posedge clock_i); #1;
        chk("coincide_enable", enable_o, 1);
        chk("coincide_hsynct", hsynct_o, 11);
        @(negedge clock_i); vsync_i = 1'b0;
        vs_pulse();
        chk("coincide_load_hsynct", hsynct_o, 12);
        chk("coincide_load_enable", enable_o, 0);
        repeat (2) @(posedge clock_i); #1;
        @(negedge clock_i); vsync_i = 1'b0;

        // EN=0 during PEND applies the copy at once and stops
        wr(4'd7, 10'd600);
        wr(4'd8, 10'h003);
        wr(4'd8, 10'h000);
        chk("stop_vfporch", vfporch_o, 600);
        chk("stop_enable", enable_o, 0);
        rd(4'd8, rd_val); chk("stop_ctrl", rd_val, 0);

        // 6: asynchronous reset while pending
        wr(4'd8, 10'h001);
        wr(4'd6, 10'd500);
        wr(4'd8, 10'h003);
        #3 reset_ni = 1'b0;
        #1;
        chk("arst_vactive", vactive_o, 514);
        chk("arst_hsynct", hsynct_o, 11);
        chk("arst_vfporch", vfporch_o, 524);
        chk("arst_enable", enable_o, 0);
        chk("arst_ack", ack_o, 0);
        @(negedge clock_i); reset_ni = 1'b1;
        rd(4'd8, rd_val); chk("arst_ctrl", rd_val, 0);
        rd(4'd6, rd_val); chk("arst_shadow", rd_val, 514);
        vs_pulse();
        repeat (2) @(posedge clock_i); #1;
        chk("arst_idle_enable", enable_o, 0);
        chk("arst_idle_vactive", vactive_o, 514);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crtc_ctrl.md
Name: crtc_ctrl

Overview:
Configuration and sequencing controller for the CRTC timing generator. It presents a small register bus to the host CPU and holds shadow copies of the eight horizontal and vertical timing thresholds. It validates committed timing and applies it to the CRTC only at a frame boundary, so a running display never sees a torn mode change. It also owns the CRTC enable.

Parameters:
WIDTH, 10, width of every timing register, the CRTC threshold ports and the data bus.

Ports:
clock_i  in  1  character clock, shared with the CRTC
reset_ni  in  1  asynchronous active-low reset
cyc_i  in  1  bus cycle
stb_i  in  1  bus strobe
we_i  in  1  write enable
adr_i  in  4  register address
dat_i  in  WIDTH  write data
dat_o  out  WIDTH  read data, valid while ack_o is high
ack_o  out  1  single-cycle acknowledge
vsync_i  in  1  CRTC vsync_o, used as the frame-boundary marker
hsynct_o, hbporch_o, hactive_o, hfporch_o  out  WIDTH each  active horizontal thresholds to the CRTC
vsynct_o, vbporch_o, vactive_o, vfporch_o  out  WIDTH each  active vertical thresholds to the CRTC
enable_o  out  1  CRTC enable_i
irq_o  out  1  frame interrupt (only with the optional feature)

Behaviour:
- Register map: adr 0-7 select the shadow registers hsynct, hbporch, hactive, hfporch, vsynct, vbporch, vactive, vfporch. adr 8 is CTRL. adr 9-15 read 0 and ignore writes.
- CTRL bits:
  - bit0 EN: read/write.
  - bit1 COMMIT: write-only, reads 0.
  - bit2 PEND: read-only.
  - bit3 ERR: read-only.
  - bit4 IRQ: write-1-to-clear.
- Bus handshake:
  - ack_o rises the cycle after cyc_i & stb_i, for exactly one cycle, then stays low for at least one cycle.
  - A held strobe therefore produces acks at most every second cycle.
  - Writes take effect on the ack edge.
  - Reads of adr 0-7 return the shadow registers, not the active ones.
- Reset values:
  - Shadow and active registers: 11, 17, 97, 99, 1, 34, 514, 524.
  - EN=0, PEND=0, ERR=0, IRQ=0.
  - enable_o=0, ack_o=0, dat_o=0, irq_o=0.
- Validation on COMMIT: the commit is accepted only if hsynct<hbporch<hactive<hfporch and vsynct<vbporch<vactive<vfporch, comparing shadow values unsigned.
  - On failure: ERR=1, no state change, active registers untouched.
  - On success: ERR=0.
- FSM states are IDLE, RUN, PEND and LOAD.
- IDLE (EN=0, enable_o=0):
  - A valid commit copies shadow to active on the next clock edge.
  - Writing EN=1 moves to RUN; enable_o rises the following cycle.
- RUN (enable_o=1):
  - A valid commit sets PEND=1 and moves to PEND.
  - Writing EN=0 moves to IDLE; enable_o falls the next cycle.
- PEND:
  - Waits for a vsync_i rising edge, detected against a registered copy of vsync_i.
  - On the edge, moves to LOAD.
  - Shadow writes during PEND are allowed; the values present at LOAD are the ones applied.
  - A further COMMIT during PEND is revalidated; if invalid, ERR=1 and the pending commit is cancelled (PEND=0, back to RUN).
  - Writing EN=0 during PEND applies the copy immediately, clears PEND and moves to IDLE.
- LOAD:
  - Two cycles long, with enable_o=0 to restart the CRTC counters.
  - Active registers are updated on the first LOAD cycle.
  - PEND clears on exit; the FSM then returns to RUN with enable_o=1.
- Simultaneous events:
  - A COMMIT write in the same cycle as a vsync edge while in RUN does not skip a frame: it waits for the next edge.
  - Reset mid-operation (any state) restores all reset values asynchronously.
- Active outputs are registered and change only on an accepted copy.

Optional Feature:
Macro CRTC_CTRL_IRQ_EN.
- Defined: a vsync_i rising edge sets CTRL.IRQ and irq_o, a level output equal to CTRL.IRQ. Writing 1 to bit4 clears it. If a set and a clear coincide, the set wins.
- Undefined: irq_o is tied to 0, bit4 reads 0, and writes to bit4 are ignored.

Test Plan:
1. Release reset → active outputs 11, 17, 97, 99, 1, 34, 514, 524; enable_o=0; ack_o=0; CTRL reads 0x00.
2. With EN=0, write hactive=81, hfporch=83, then COMMIT → hactive_o=81 and hfporch_o=83 one cycle after the ack; no vsync needed; PEND never set.
3. EN=1 (enable_o=1), write vactive=400, vfporch=410, COMMIT → CTRL reads PEND=1 and vactive_o stays 514 until the vsync_i rising edge; then enable_o=0 for exactly 2 cycles, vactive_o=400, PEND=0, enable_o=1.
4. Write hbporch=20, hactive=15, COMMIT → ERR=1, PEND=0, active registers unchanged; fix hactive=97 and COMMIT → ERR=0.
5. With the IRQ feature: vsync_i rising edge → irq_o=1; write CTRL bit4=1 → irq_o=0 after the ack; a clear coinciding with an edge → irq_o stays 1.
6. Assert reset_ni while in PEND → all outputs return to reset values immediately, and the state is IDLE after release.
